// File: rtl/ven_pkg.sv
// Shared definitions for the vending-machine coin path: coin codes and
// arbiter state encoding.
package ven_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_A    = 2'b01;
   localparam logic [1:0] COIN_B    = 2'b10;
   localparam logic [1:0] COIN_C    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_HOLD = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ven_rr_pick.sv
// Combinational round-robin picker: first set bit of full at or after rr,
// ascending with wrap-around.
module ven_rr_pick #(
   parameter int NSLOT = 4,
   parameter int IW    = $clog2(NSLOT)
) (
   input  logic [NSLOT-1:0] full,
   input  logic [IW-1:0]    rr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   logic [IW:0] pos;

   // Scan from the farthest offset down so the nearest full slot is the last write.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = NSLOT - 1; k >= 0; k--) begin
         pos = {1'b0, rr} + (IW + 1)'(k);
         if (pos >= (IW + 1)'(NSLOT))
            pos = pos - (IW + 1)'(NSLOT);
         if (full[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/ven_coin_arb.sv
// Round-robin coin arbiter: per-slot one-coin buffers feeding ven_mach's
// single coin input, one coin per two cycles, paused after each dispense.
module ven_coin_arb
   import ven_pkg::*;
#(
   parameter int NSLOT = 4,
   parameter int HOLD  = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NSLOT-1:0]         slot_valid,
   input  logic [2*NSLOT-1:0]       slot_coin,
   output logic [NSLOT-1:0]         slot_ready,
   output logic [1:0]               vm_coin,
   input  logic                     vm_x,
   output logic [$clog2(NSLOT)-1:0] grant_id,
   output logic                     busy,
   output logic [7:0]               coin_cnt
);

   localparam int IW = $clog2(NSLOT);
   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

   arb_state_t              state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           rr;
   logic [NSLOT-1:0]        full;
   logic [NSLOT-1:0][1:0]   buf_code;
   logic                    issue;
   logic                    pick_found;
   logic [IW-1:0]           pick_idx;

   ven_rr_pick #(.NSLOT(NSLOT), .IW(IW)) u_pick (
      .full  (full),
      .rr    (rr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign slot_ready = ~full;
   assign busy       = (state != ST_IDLE) || (|full);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      issue     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vm_x) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CW'(HOLD - 1);
            end else if (pick_found) begin
               issue     = 1'b1;
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (vm_x) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CW'(HOLD - 1);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // vm_x is deliberately ignored here; the window only counts down.
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - CW'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         rr       <= '0;
         vm_coin  <= COIN_NONE;
         grant_id <= '0;
         coin_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         vm_coin <= issue ? buf_code[pick_idx] : COIN_NONE;
         if (issue) begin
            grant_id <= pick_idx;
            rr       <= (pick_idx == IW'(NSLOT - 1)) ? '0 : pick_idx + IW'(1);
            coin_cnt <= coin_cnt + 8'd1;
         end
      end
   end

   // A slot being issued is still full at that edge, so it cannot refill then.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full     <= '0;
         buf_code <= '0;
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            if (issue && pick_idx == IW'(i)) begin
               full[i] <= 1'b0;
            end else if (slot_valid[i] && !full[i] &&
                         slot_coin[2*i +: 2] != COIN_NONE) begin
               full[i]     <= 1'b1;
               buf_code[i] <= slot_coin[2*i +: 2];
            end
         end
      end
   end

endmodule

// File: tb/tb_ven_coin_arb.sv
// Directed self-checking bench for ven_coin_arb (NSLOT=4, HOLD=2).
module tb_ven_coin_arb;

   logic       clock;
   logic       reset;
   logic [3:0] slot_valid;
   logic [7:0] slot_coin;
   logic [3:0] slot_ready;
   logic [1:0] vm_coin;
   logic       vm_x;
   logic [1:0] grant_id;
   logic       busy;
   logic [7:0] coin_cnt;

   int checks = 0;
   int errors = 0;

   ven_coin_arb #(.NSLOT(4), .HOLD(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .slot_valid (slot_valid),
      .slot_coin  (slot_coin),
      .slot_ready (slot_ready),
      .vm_coin    (vm_coin),
      .vm_x       (vm_x),
      .grant_id   (grant_id),
      .busy       (busy),
      .coin_cnt   (coin_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      slot_valid = '0;
      slot_coin  = '0;
      vm_x       = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (vm_coin !== 2'b00 || slot_ready !== 4'b1111 || busy !== 1'b0 ||
             coin_cnt !== 8'd0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d got coin=%b rdy=%b busy=%b cnt=%0d gid=%0d exp coin=00 rdy=1111 busy=0 cnt=0 gid=0",
                     c, vm_coin, slot_ready, busy, coin_cnt, grant_id);
         end
         step();
      end
   endtask

   task automatic test_single();
      do_reset();
      slot_valid = 4'b0100;
      slot_coin  = 8'b00_01_00_00;
      step();
      slot_valid = '0;
      slot_coin  = '0;
      checks++;
      if (slot_ready !== 4'b1011 || vm_coin !== 2'b00 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_capture got rdy=%b coin=%b busy=%b exp rdy=1011 coin=00 busy=1",
                  slot_ready, vm_coin, busy);
      end
      step();
      checks++;
      if (vm_coin !== 2'b01 || grant_id !== 2'd2 || coin_cnt !== 8'd1 || slot_ready !== 4'b1111) begin
         errors++;
         $display("FAIL single_issue got coin=%b gid=%0d cnt=%0d rdy=%b exp coin=01 gid=2 cnt=1 rdy=1111",
                  vm_coin, grant_id, coin_cnt, slot_ready);
      end
      step();
      checks++;
      if (vm_coin !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_gap got coin=%b busy=%b exp coin=00 busy=0", vm_coin, busy);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_coin [6];
      logic [1:0] exp_gid  [6];
      exp_coin = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
      exp_gid  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3};
      do_reset();
      slot_valid = 4'b1011;
      slot_coin  = 8'b11_00_01_10;
      step();
      slot_valid = '0;
      slot_coin  = '0;
      checks++;
      if (slot_ready !== 4'b0100) begin
         errors++;
         $display("FAIL fair_capture got rdy=%b exp 0100", slot_ready);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if (vm_coin !== exp_coin[c] || grant_id !== exp_gid[c]) begin
            errors++;
            $display("FAIL fair_seq cyc%0d got coin=%b gid=%0d exp coin=%b gid=%0d",
                     c, vm_coin, grant_id, exp_coin[c], exp_gid[c]);
         end
      end
      checks++;
      if (coin_cnt !== 8'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fair_count got cnt=%0d busy=%b exp cnt=3 busy=0", coin_cnt, busy);
      end
   endtask

   task automatic test_dispense_hold();
      do_reset();
      slot_valid = 4'b0011;
      slot_coin  = 8'b00_00_10_01;
      step();
      slot_valid = '0;
      slot_coin  = '0;
      step();
      checks++;
      if (vm_coin !== 2'b01 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL hold_first got coin=%b gid=%0d exp coin=01 gid=0", vm_coin, grant_id);
      end
      vm_x = 1'b1;
      step();
      vm_x = 1'b0;
      // HOLD, HOLD, then back in IDLE: coin stays 00 for three sampled cycles
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (vm_coin !== 2'b00 || slot_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait cyc%0d got coin=%b rdy1=%b exp coin=00 rdy1=0",
                     c, vm_coin, slot_ready[1]);
         end
         step();
      end
      checks++;
      if (vm_coin !== 2'b10 || grant_id !== 2'd1 || coin_cnt !== 8'd2) begin
         errors++;
         $display("FAIL hold_release got coin=%b gid=%0d cnt=%0d exp coin=10 gid=1 cnt=2",
                  vm_coin, grant_id, coin_cnt);
      end
      // vm_x in IDLE with a full buffer blocks the issue
      slot_valid = 4'b0001;
      slot_coin  = 8'b00_00_00_11;
      step();
      slot_valid = '0;
      slot_coin  = '0;
      vm_x       = 1'b1;
      step();
      vm_x = 1'b0;
      checks++;
      if (vm_coin !== 2'b00 || coin_cnt !== 8'd2 || slot_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_idle_block got coin=%b cnt=%0d rdy0=%b exp coin=00 cnt=2 rdy0=0",
                  vm_coin, coin_cnt, slot_ready[0]);
      end
      step();
      step();
      step();
      checks++;
      if (vm_coin !== 2'b11 || coin_cnt !== 8'd3) begin
         errors++;
         $display("FAIL hold_idle_release got coin=%b cnt=%0d exp coin=11 cnt=3", vm_coin, coin_cnt);
      end
   endtask

   task automatic test_zero_filter();
      do_reset();
      slot_valid = 4'b0001;
      slot_coin  = 8'b00_00_00_00;
      step();
      checks++;
      if (slot_ready !== 4'b1111 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_capture got rdy=%b busy=%b exp rdy=1111 busy=0", slot_ready, busy);
      end
      step();
      step();
      slot_valid = '0;
      checks++;
      if (vm_coin !== 2'b00 || coin_cnt !== 8'd0) begin
         errors++;
         $display("FAIL zero_issue got coin=%b cnt=%0d exp coin=00 cnt=0", vm_coin, coin_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_coin [4];
      exp_coin = '{2'b11, 2'b00, 2'b11, 2'b00};
      do_reset();
      slot_valid = 4'b0100;
      slot_coin  = 8'b00_11_00_00;
      step();
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (vm_coin !== exp_coin[c]) begin
            errors++;
            $display("FAIL b2b_seq cyc%0d got coin=%b exp %b", c, vm_coin, exp_coin[c]);
         end
         if (c == 0) begin
            checks++;
            if (slot_ready[2] !== 1'b1) begin
               errors++;
               $display("FAIL b2b_no_refill got rdy2=%b exp 1", slot_ready[2]);
            end
         end
         if (c == 2) slot_valid = '0;
      end
      checks++;
      if (coin_cnt !== 8'd2) begin
         errors++;
         $display("FAIL b2b_count got cnt=%0d exp 2", coin_cnt);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      slot_valid = 4'b1011;
      slot_coin  = 8'b01_00_10_11;
      step();
      slot_valid = '0;
      slot_coin  = '0;
      step();
      checks++;
      if (vm_coin !== 2'b11 || slot_ready !== 4'b0101) begin
         errors++;
         $display("FAIL midrst_pre got coin=%b rdy=%b exp coin=11 rdy=0101", vm_coin, slot_ready);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (vm_coin !== 2'b00 || slot_ready !== 4'b1111 || coin_cnt !== 8'd0 ||
          busy !== 1'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL midrst_async got coin=%b rdy=%b cnt=%0d busy=%b gid=%0d exp coin=00 rdy=1111 cnt=0 busy=0 gid=0",
                  vm_coin, slot_ready, coin_cnt, busy, grant_id);
      end
      step();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (vm_coin !== 2'b00 || coin_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_after cyc%0d got coin=%b cnt=%0d exp coin=00 cnt=0",
                     c, vm_coin, coin_cnt);
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      slot_valid = '0;
      slot_coin  = '0;
      vm_x       = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_dispense_hold();
      test_zero_filter();
      test_back_to_back();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ven_coin_arb.md
# ven_coin_arb

Round-robin coin arbiter and sequencer that lets several coin slots share the single 2-bit coin input of the vending machine FSM (`ven_mach`). It gives each slot a one-coin holding buffer with a valid/ready handshake, and forwards exactly one coin per issue cycle followed by a mandatory idle cycle. It suspends issuing for a programmable hold window whenever the machine signals a dispense. It sits between the coin-slot front ends and `ven_mach`, and its `vm_coin` output drives `ven_mach`'s coin input directly.

## Interface
- NSLOT, 4: number of coin slots (2..8).
- HOLD, 2: idle cycles enforced after a dispense is seen (≥1).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- slot_valid  in  NSLOT  slot i offers a coin.
- slot_coin  in  2*NSLOT  coin code of slot i at bits [2i+1:2i].
- slot_ready  out  NSLOT  slot i buffer empty (combinational from buffer state).
- vm_coin  out  2  registered coin code to ven_mach; 00 = no coin.
- vm_x  in  1  dispense indication from ven_mach.
- grant_id  out  $clog2(NSLOT)  slot whose coin was last issued.
- busy  out  1  state≠IDLE or any buffer full.
- coin_cnt  out  8  coins issued since reset; wraps mod 256.

## Operation
- Capture: at an edge with slot_valid[i]&&slot_ready[i], slot i's code is stored and the buffer becomes full. A code of 00 is ignored: nothing is stored. Codes 01/10/11 are forwarded unmodified.
- Clear: the buffer of slot i empties only at the edge where slot i is issued. It cannot be refilled at that same edge.
- FSM states: IDLE, GAP, HOLD.
  - IDLE, vm_x=1: go to HOLD and load cnt=HOLD-1. No issue occurs, even if a buffer is full.
  - IDLE, vm_x=0, any buffer full: pick slot j by round robin. Set vm_coin<=code_j, grant_id<=j, clear buffer j, rr<=j+1 (mod NSLOT), coin_cnt+=1, and go to GAP.
  - IDLE, otherwise: stay. vm_coin is 00.
  - GAP: vm_coin<=00. If vm_x=1 go to HOLD with cnt=HOLD-1, else go to IDLE.
  - HOLD: vm_coin is 00. If cnt==0 go to IDLE, else cnt-=1. vm_x is ignored while in HOLD.
- Round robin: search begins at rr and ascends with wrap. The first full buffer wins.
- vm_coin is nonzero for exactly one cycle per issued coin and is always followed by at least one 00 cycle.

## Timing
- Reset values: state=IDLE, all buffers empty (slot_ready all 1), vm_coin=00, grant_id=0, rr=0, cnt=0, coin_cnt=0, busy=0.
- Latency: coin captured at edge E0, issued at edge E1 when the FSM is in IDLE and vm_x=0. vm_coin holds the code during cycle E1→E2.
- The earliest recapture on the same slot is edge E2.
- Peak throughput: one coin per 2 cycles, shared across all slots.
- vm_x seen in IDLE/GAP: exactly HOLD cycles in HOLD, then IDLE. The next issue occurs at the earliest at the edge after re-entering IDLE.
- Simultaneous capture on several slots: all are stored. They are issued in round-robin order on successive issue opportunities.
- Reset asserted mid-operation: all outputs return immediately to their reset values and pending coins are discarded. There is no glitch-free requirement on vm_coin beyond the asynchronous clear.

## Structure
- Shared package `ven_pkg`:
  - coin code constants COIN_NONE=2'b00, COIN_A=2'b01, COIN_B=2'b10, COIN_C=2'b11.
  - arbiter state encoding IDLE/GAP/HOLD.
- Sub-module `ven_rr_pick`: combinational round-robin picker. Inputs: full vector and rr. Outputs: found flag and winning index.
- The top level holds the buffers, FSM, hold counter and coin counter.

## Test plan
- Reset then idle: reset low for 2 cycles then high, no valids → vm_coin=00, slot_ready=4'b1111, busy=0, coin_cnt=0 throughout.
- Single coin: slot 2 presents 01 for one edge → slot_ready[2]=0 for 1 cycle; vm_coin=01 for exactly 1 cycle, one cycle later; grant_id=2, coin_cnt=1.
- Fairness: slots 0,1,3 present 10,01,11 on the same edge → issued in order 0,1,3. vm_coin sequence is 10,00,01,00,11,00, and coin_cnt=3.
- Dispense hold (HOLD=2): assert vm_x during GAP while slot 1 holds 10 → two cycles of vm_coin=00 in HOLD, then 10 is issued on the next IDLE edge.
- Zero filtering: slot 0 valid with 00 → slot_ready[0] stays 1, no issue, coin_cnt unchanged.
- Reset mid-flight: assert reset while vm_coin=11 with two buffers full → vm_coin=00 immediately, all buffers empty, coin_cnt=0, and no issue after release.
